// File: rtl/scan_pkg.sv
// scan_pkg: shared FSM/detector state encodings and the scanned pattern
package scan_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} fsm_t;
   typedef enum logic [1:0] {S0, S1, S2, S3} det_t;
   localparam logic [3:0] PATTERN = 4'b1011;
endpackage

// File: rtl/seq_det_mealy.sv
// seq_det_mealy: overlapping Mealy detector for PATTERN, advancing only when en=1
module seq_det_mealy
   import scan_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   input  logic bit_in,
   output logic z
);
   det_t st, nxt;
   // next detector state and same-cycle match output
   always_comb begin
      nxt = st == S0 ? (bit_in ? S1 : S0) :
            st == S1 ? (bit_in ? S1 : S2) :
            st == S2 ? (bit_in ? S3 : S0) :
                       (bit_in ? S1 : S2);
      z = en && st == S3 && bit_in == PATTERN[0];
   end
   // detector state register; clr restarts history at S0
   always_ff @(posedge clk) begin
      if (!reset || clr) st <= S0;
      else if (en) st <= nxt;
   end
endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: scans a parallel word MSB-first through seq_det_mealy; SCAN_CARRY_EN keeps detector history across words
module pattern_scan_ctrl
   import scan_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4,
   parameter int POS_W  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   output logic              busy,
   output logic              done,
   output logic              serial_bit,
   output logic              z,
   output logic [CNT_W-1:0]  match_count,
   output logic              found,
   output logic [POS_W-1:0]  first_pos
);
   fsm_t state, nxt;
   logic [DATA_W-1:0] sreg;
   logic [POS_W-1:0] idx;
   logic accept, last, en, clr;
   // next-state and status outputs
   always_comb begin
      accept = state == IDLE && start;
      last = idx == POS_W'(DATA_W - 1);
      nxt = state == IDLE ? (start ? SHIFT : IDLE) :
            state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
      busy = state != IDLE;
      done = state == DONE;
      en = state == SHIFT;
      serial_bit = en && sreg[DATA_W-1];
   end
`ifdef SCAN_CARRY_EN
   assign clr = 1'b0;
`else
   assign clr = accept;
`endif
   seq_det_mealy u_det (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr),
      .en     (en),
      .bit_in (serial_bit),
      .z      (z)
   );
   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else state <= nxt;
   end
   // shift register, bit index and result registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         sreg <= '0;
         idx <= '0;
         match_count <= '0;
         found <= 1'b0;
         first_pos <= '0;
      end else if (accept) begin
         sreg <= data_in;
         idx <= '0;
         match_count <= '0;
         found <= 1'b0;
         first_pos <= '0;
      end else if (en) begin
         sreg <= sreg << 1;
         idx <= idx + POS_W'(1);
         if (z) begin
            if (match_count != '1) match_count <= match_count + CNT_W'(1);
            found <= 1'b1;
            if (!found) first_pos <= idx;
         end
      end
   end
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: directed scoreboard bench for pattern_scan_ctrl
module tb_pattern_scan_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic [7:0] data_in = '0;
   logic busy, done, serial_bit, z, found;
   logic [3:0] match_count;
   logic [2:0] first_pos;
   int checks = 0;
   int failures = 0;
   typedef struct {
      logic [7:0] zm;
      logic [3:0] cnt;
      logic       fnd;
      logic [2:0] pos;
   } exp_t;
   exp_t sb[$];

   pattern_scan_ctrl #(.DATA_W(8), .CNT_W(4), .POS_W(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .data_in     (data_in),
      .busy        (busy),
      .done        (done),
      .serial_bit  (serial_bit),
      .z           (z),
      .match_count (match_count),
      .found       (found),
      .first_pos   (first_pos)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_sbit"}, serial_bit, 0);
      chk({tag, "_z"}, z, 0);
      chk({tag, "_cnt"}, match_count, 0);
      chk({tag, "_found"}, found, 0);
      chk({tag, "_pos"}, first_pos, 0);
   endtask

   // zm holds expected z per bit index, MSB = index 0; dup re-pulses start at that index
   task automatic scan(input string tag, input logic [7:0] d, input logic [7:0] zm,
                       input logic [3:0] c, input logic f, input logic [2:0] p, input int dup);
      exp_t e;
      e.zm = zm; e.cnt = c; e.fnd = f; e.pos = p;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b1;
      data_in = d;
      @(negedge clk);
      start = 1'b0;
      data_in = 8'h55;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         start = (i == dup);
         chk({tag, "_busy"}, busy, 1);
         chk({tag, "_done_lo"}, done, 0);
         chk({tag, "_sbit"}, serial_bit, d[7-i]);
         chk({tag, "_z"}, z, zm[7-i]);
      end
      @(negedge clk);
      start = 1'b0;
      e = sb.pop_front();
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_done"}, busy, 1);
      chk({tag, "_sbit_done"}, serial_bit, 0);
      chk({tag, "_z_done"}, z, 0);
      chk({tag, "_cnt"}, match_count, e.cnt);
      chk({tag, "_found"}, found, e.fnd);
      chk({tag, "_pos"}, first_pos, e.pos);
      @(negedge clk);
      chk({tag, "_done_w"}, done, 0);
      chk({tag, "_busy_idle"}, busy, 0);
      chk({tag, "_cnt_hold"}, match_count, e.cnt);
      chk({tag, "_pos_hold"}, first_pos, e.pos);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_idle_zero("rst");
      reset = 1'b1;
      @(negedge clk);
      scan("w1", 8'b10110110, 8'b00010010, 4'd2, 1'b1, 3'd3, -1);
      scan("w00", 8'h00, 8'h00, 4'd0, 1'b0, 3'd0, -1);
      scan("wbb", 8'b10111011, 8'b00010001, 4'd2, 1'b1, 3'd3, -1);
      scan("dup", 8'hB0, 8'b00010000, 4'd1, 1'b1, 3'd3, 2);
      @(negedge clk);
      start = 1'b1;
      data_in = 8'hBB;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk_idle_zero("abort");
      reset = 1'b1;
      scan("clean", 8'b10110110, 8'b00010010, 4'd2, 1'b1, 3'd3, -1);
      scan("c1", 8'b00000101, 8'h00, 4'd0, 1'b0, 3'd0, -1);
`ifdef SCAN_CARRY_EN
      scan("c2", 8'b10000000, 8'b10000000, 4'd1, 1'b1, 3'd0, -1);
`else
      scan("c2", 8'b10000000, 8'h00, 4'd0, 1'b0, 3'd0, -1);
`endif
      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
